// File: rtl/md_if.sv
// Handshake bundle between the E-stage issue logic and the multiply/divide sequencer.
interface md_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_useD;
  logic        hilo_sel;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdout;
  logic        busy;
  logic        md_stall;

  modport master (
    output start, op, a, b, md_useD, hilo_sel,
    input  hi, lo, mdout, busy, md_stall
  );

  modport slave (
    input  start, op, a, b, md_useD, hilo_sel,
    output hi, lo, mdout, busy, md_stall
  );
endinterface

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, counts out fixed mult/div latency and
// raises a stall for HI/LO-dependent instructions in D while a result is pending.
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic rst,
  md_if.slave md
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   hi_r, lo_r, hi_n, lo_n;
  logic [31:0]   pend_hi, pend_lo, pend_hi_n, pend_lo_n;
  logic          pend_wr, pend_wr_n;
  logic          busy;

  logic [63:0] prod_s, prod_u;
  logic [31:0] dvsr, q_u, r_u, a_mag, b_mag, q_mag, r_mag, q_s, r_s;
  logic        div_zero;

  // Signed divide works on magnitudes so that 0x80000000 / -1 wraps cleanly.
  always_comb begin
    prod_s   = {{32{md.a[31]}}, md.a} * {{32{md.b[31]}}, md.b};
    prod_u   = {32'd0, md.a} * {32'd0, md.b};
    div_zero = (md.b == 32'd0);
    dvsr     = div_zero ? 32'd1 : md.b;
    q_u      = md.a / dvsr;
    r_u      = md.a % dvsr;
    a_mag    = md.a[31] ? -md.a : md.a;
    b_mag    = dvsr[31] ? -dvsr : dvsr;
    q_mag    = a_mag / b_mag;
    r_mag    = a_mag % b_mag;
    q_s      = (md.a[31] ^ dvsr[31]) ? -q_mag : q_mag;
    r_s      = md.a[31] ? -r_mag : r_mag;
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hi_n      = hi_r;
    lo_n      = lo_r;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    pend_wr_n = pend_wr;
    case (state)
      IDLE: begin
        if (md.start) begin
          case (md.op)
            OP_MULT: begin
              {pend_hi_n, pend_lo_n} = prod_s;
              pend_wr_n = 1'b1;
              cnt_n     = CW'(MULT_CYCLES);
              state_n   = RUN;
            end
            OP_MULTU: begin
              {pend_hi_n, pend_lo_n} = prod_u;
              pend_wr_n = 1'b1;
              cnt_n     = CW'(MULT_CYCLES);
              state_n   = RUN;
            end
            OP_DIV: begin
              pend_hi_n = r_s;
              pend_lo_n = q_s;
              pend_wr_n = ~div_zero;
              cnt_n     = CW'(DIV_CYCLES);
              state_n   = RUN;
            end
            OP_DIVU: begin
              pend_hi_n = r_u;
              pend_lo_n = q_u;
              pend_wr_n = ~div_zero;
              cnt_n     = CW'(DIV_CYCLES);
              state_n   = RUN;
            end
            OP_MTHI: hi_n = md.a;
            OP_MTLO: lo_n = md.a;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Any issue while running is dropped; hazard logic never lets one through.
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n   = IDLE;
          pend_wr_n = 1'b0;
          if (pend_wr) begin
            hi_n = pend_hi;
            lo_n = pend_lo;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      hi_r    <= '0;
      lo_r    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      hi_r    <= hi_n;
      lo_r    <= lo_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
      pend_wr <= pend_wr_n;
    end
  end

  assign busy        = (cnt != '0);
  assign md.busy     = busy;
  assign md.hi       = hi_r;
  assign md.lo       = lo_r;
  assign md.mdout    = md.hilo_sel ? hi_r : lo_r;
  assign md.md_stall = md.md_useD & (busy | (md.start & (md.op <= OP_DIVU)));

endmodule
